// File: rtl/acl_event_ctrl.sv
// Accelerometer event controller: per-channel debounce, event flag/count latch with read handshake.
// acl_out updates on the edge that captures the qualifying sample; ACL_EVENT_HOLDOFF_EN adds a post-read re-arm delay.
module acl_event_ctrl #(
  parameter int NUM_CH      = 3,
  parameter int SAMPLE_W    = 10,
  parameter int DEBOUNCE    = 2,
  parameter int HOLDOFF_CYC = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]   sample_data,
  input  logic [SAMPLE_W-1:0]          thr,
  input  logic                         has_been_read,
  output logic [15:0]                  acl_out
);

  localparam int DBW = 4;

  typedef enum logic [1:0] {
    RECEIVE = 2'd0,
    SEND    = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  if (NUM_CH < 1 || NUM_CH > 7) begin : g_chk_num_ch
    $error("NUM_CH must be 1..7");
  end
  if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_chk_debounce
    $error("DEBOUNCE must be 1..15");
  end
  if (HOLDOFF_CYC < 1 || HOLDOFF_CYC > 255) begin : g_chk_holdoff
    $error("HOLDOFF_CYC must be 1..255");
  end

  state_t         state_q, state_d;
  logic [DBW-1:0] dbc_q [NUM_CH];
  logic [DBW-1:0] dbc_d [NUM_CH];
  logic [6:0]     evt;
  logic [6:0]     flags_q, flags_d;
  logic [7:0]     cnt_q, cnt_d, cnt_sat;
  logic [8:0]     cnt_sum;
  logic [3:0]     evt_num;
  logic           pend_q;
`ifdef ACL_EVENT_HOLDOFF_EN
  logic [7:0]     hold_q, hold_d;
`endif

  // An event fires only on the step into DEBOUNCE; a saturated counter stays silent until cleared.
  always_comb begin
    evt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      dbc_d[k] = dbc_q[k];
      if (sample_valid) begin
        if (sample_data[k*SAMPLE_W +: SAMPLE_W] >= thr) begin
          if (dbc_q[k] != DBW'(DEBOUNCE)) begin
            dbc_d[k] = dbc_q[k] + 1'b1;
            if (dbc_q[k] == DBW'(DEBOUNCE - 1)) begin
              evt[k] = 1'b1;
            end
          end
        end else begin
          dbc_d[k] = '0;
        end
      end
    end
  end

  always_comb begin
    evt_num = '0;
    for (int k = 0; k < 7; k++) begin
      evt_num = evt_num + {3'b000, evt[k]};
    end
    cnt_sum = {1'b0, cnt_q} + {5'b00000, evt_num};
    cnt_sat = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
`ifdef ACL_EVENT_HOLDOFF_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      RECEIVE: begin
        if (|evt) begin
          flags_d = evt;
          cnt_d   = {4'b0000, evt_num};
          state_d = SEND;
        end
      end
      SEND: begin
        if (has_been_read) begin
          // A same-cycle event replaces the consumed report instead of being dropped.
          if (|evt) begin
            flags_d = evt;
            cnt_d   = {4'b0000, evt_num};
          end else begin
            flags_d = '0;
            cnt_d   = '0;
`ifdef ACL_EVENT_HOLDOFF_EN
            hold_d  = '0;
            state_d = HOLDOFF;
`else
            state_d = RECEIVE;
`endif
          end
        end else begin
          flags_d = flags_q | evt;
          cnt_d   = cnt_sat;
        end
      end
      HOLDOFF: begin
`ifdef ACL_EVENT_HOLDOFF_EN
        hold_d = hold_q + 8'd1;
        if (hold_q == 8'(HOLDOFF_CYC - 1)) begin
          hold_d  = '0;
          state_d = RECEIVE;
        end
`else
        state_d = RECEIVE;
`endif
      end
      default: state_d = RECEIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RECEIVE;
      flags_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        dbc_q[k] <= '0;
      end
`ifdef ACL_EVENT_HOLDOFF_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      pend_q  <= (state_d == SEND);
      for (int k = 0; k < NUM_CH; k++) begin
        dbc_q[k] <= dbc_d[k];
      end
`ifdef ACL_EVENT_HOLDOFF_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign acl_out = {cnt_q, flags_q, pend_q};

endmodule
